// File: rtl/witf_tracker.sv
// ============================================================================
// Module   : witf_tracker
// Brief    : Write-in-flight tracker. It records in-flight destination
//            registers, flags RAW hazards for decode and reports full/empty.
//            Optional macro WITF_WB_BYPASS_EN excludes the head entry that is
//            retiring this cycle from the RAW match.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module witf_tracker #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_en,
  input  logic [AW-1:0]            disp_rd,
  input  logic [NSRC*AW-1:0]       rs,
  input  logic [NSRC-1:0]          rs_valid,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_rd,
  output logic                     raw,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     order_err
);

  localparam int                  c_ptr_w    = $clog2(DEPTH);
  localparam int                  c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_full_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [AW-1:0]      rd_q [DEPTH];
  logic [AW-1:0]      rd_d [DEPTH];
  logic [c_ptr_w-1:0] head_q, head_d;
  logic [c_ptr_w-1:0] tail_q, tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               order_err_q, order_err_d;

  logic               push_w;
  logic               pop_w;
  logic               full_w;
  logic               empty_w;
  logic [DEPTH-1:0]   live_w;
  logic               raw_w;

  // Occupancy comes from the counter, because head == tail is ambiguous.
  assign full_w  = (count_q == c_full_cnt);
  assign empty_w = (count_q == '0);
  assign push_w  = disp_en && !full_w && (disp_rd != '0);
  assign pop_w   = wb_valid && !empty_w;

  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    order_err_d = order_err_q;

    if (push_w) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = disp_rd;
      tail_d          = tail_q + c_ptr_one;
    end
    // Push and pop cannot hit the same slot, since that would need an empty or full buffer.
    if (pop_w) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + c_ptr_one;
    end

    case ({push_w, pop_w})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    if (wb_valid && (empty_w || (wb_rd != rd_q[head_q]))) begin
      order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rd_q[e] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      order_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      order_err_q <= order_err_d;
    end
  end

  generate
    for (genvar e = 0; e < DEPTH; e++) begin : g_live
`ifdef WITF_WB_BYPASS_EN
      // The retiring head is write-through forwarded, so it no longer blocks its dependants.
      assign live_w[e] = valid_q[e] && !(pop_w && (head_q == c_ptr_w'(e)));
`else
      assign live_w[e] = valid_q[e];
`endif
    end
  endgenerate

  always_comb begin
    raw_w = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (rs_valid[i] && (rs[i*AW +: AW] != '0)) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (live_w[e] && (rd_q[e] == rs[i*AW +: AW])) begin
            raw_w = 1'b1;
          end
        end
      end
    end
  end

  assign raw       = raw_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign order_err = order_err_q;

endmodule

`default_nettype wire

// File: tb/tb_witf_tracker.sv
// ============================================================================
// Module   : tb_witf_tracker
// Brief    : Directed, table-driven self-checking bench for witf_tracker
//            (DEPTH=4, NSRC=2, AW=5), with hand-written reset/order sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_witf_tracker;

`ifdef WITF_WB_BYPASS_EN
  localparam logic c_byp = 1'b1;
`else
  localparam logic c_byp = 1'b0;
`endif
  localparam int c_nvec = 28;

  logic        clk;
  logic        rst;
  logic        disp_en;
  logic [4:0]  disp_rd;
  logic [9:0]  rs;
  logic [1:0]  rs_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        raw;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        order_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       de;
    logic [4:0] drd;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] rsv;
    logic       wbv;
    logic [4:0] wbrd;
    logic       e_raw;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_oerr;
  } vec_t;

  vec_t vecs [c_nvec];

  witf_tracker #(.DEPTH(4), .NSRC(2), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_en   (disp_en),
    .disp_rd   (disp_rd),
    .rs        (rs),
    .rs_valid  (rs_valid),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .raw       (raw),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .order_err (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_v(input int idx, input logic de, input logic [4:0] drd,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] rsv,
                       input logic wbv, input logic [4:0] wbrd, input logic e_raw,
                       input logic [2:0] e_cnt, input logic e_full, input logic e_empty,
                       input logic e_oerr);
    vecs[idx] = '{de, drd, rs0, rs1, rsv, wbv, wbrd, e_raw, e_cnt, e_full, e_empty, e_oerr};
  endtask

  task automatic drive(input logic de, input logic [4:0] drd, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] rsv, input logic wbv,
                       input logic [4:0] wbrd);
    disp_en  = de;
    disp_rd  = drd;
    rs       = {rs1, rs0};
    rs_valid = rsv;
    wb_valid = wbv;
    wb_rd    = wbrd;
  endtask

  initial begin
    // Expected values are outputs sampled before the edge that applies the vector.
    //        idx de drd rs0 rs1 rsv   wbv wbrd raw     cnt full empty oerr
    set_v( 0, 0,  0,  0,  0, 2'b00, 0,  0,  0,      0,  0,   1,    0);
    set_v( 1, 1,  5,  5,  0, 2'b01, 0,  0,  0,      0,  0,   1,    0);
    set_v( 2, 0,  0,  5,  3, 2'b01, 0,  0,  1,      1,  0,   0,    0);
    set_v( 3, 0,  0,  5,  3, 2'b10, 0,  0,  0,      1,  0,   0,    0);
    set_v( 4, 1,  0,  0,  0, 2'b11, 0,  0,  0,      1,  0,   0,    0);
    set_v( 5, 0,  0,  0,  0, 2'b00, 0,  0,  0,      1,  0,   0,    0);
    set_v( 6, 1,  6,  0,  0, 2'b00, 0,  0,  0,      1,  0,   0,    0);
    set_v( 7, 1,  7,  0,  0, 2'b00, 0,  0,  0,      2,  0,   0,    0);
    set_v( 8, 1,  8,  0,  0, 2'b00, 0,  0,  0,      3,  0,   0,    0);
    set_v( 9, 1,  9,  8,  0, 2'b01, 0,  0,  1,      4,  1,   0,    0);
    set_v(10, 0,  0,  9,  0, 2'b01, 0,  0,  0,      4,  1,   0,    0);
    set_v(11, 1,  9,  5,  0, 2'b01, 1,  5,  !c_byp, 4,  1,   0,    0);
    set_v(12, 0,  0,  9,  0, 2'b01, 0,  0,  0,      3,  0,   0,    0);
    set_v(13, 1, 10,  6,  0, 2'b01, 1,  6,  !c_byp, 3,  0,   0,    0);
    set_v(14, 0,  0, 10,  0, 2'b01, 0,  0,  1,      3,  0,   0,    0);
    set_v(15, 0,  0,  7,  0, 2'b01, 1,  7,  !c_byp, 3,  0,   0,    0);
    set_v(16, 0,  0,  0,  0, 2'b00, 1,  8,  0,      2,  0,   0,    0);
    set_v(17, 0,  0, 10,  0, 2'b01, 1, 10,  !c_byp, 1,  0,   0,    0);
    set_v(18, 0,  0,  0,  0, 2'b00, 0,  0,  0,      0,  0,   1,    0);
    set_v(19, 1, 11,  0,  0, 2'b00, 0,  0,  0,      0,  0,   1,    0);
    set_v(20, 1, 12,  0,  0, 2'b00, 0,  0,  0,      1,  0,   0,    0);
    set_v(21, 1, 13,  0, 12, 2'b10, 1, 11,  1,      2,  0,   0,    0);
    set_v(22, 1, 14,  0,  0, 2'b00, 1, 12,  0,      2,  0,   0,    0);
    set_v(23, 0,  0, 14,  0, 2'b01, 1, 13,  1,      2,  0,   0,    0);
    set_v(24, 0,  0,  0,  0, 2'b00, 1, 14,  0,      1,  0,   0,    0);
    set_v(25, 0,  0,  0,  0, 2'b00, 0,  0,  0,      0,  0,   1,    0);
    set_v(26, 0,  0,  0,  0, 2'b00, 1,  3,  0,      0,  0,   1,    0);
    set_v(27, 0,  0,  0,  0, 2'b00, 0,  0,  0,      0,  0,   1,    1);

    rst = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < c_nvec; i++) begin
      @(negedge clk);
      drive(vecs[i].de, vecs[i].drd, vecs[i].rs0, vecs[i].rs1, vecs[i].rsv,
            vecs[i].wbv, vecs[i].wbrd);
      #1;
      check($sformatf("v%0d.raw", i),   32'(raw),       32'(vecs[i].e_raw));
      check($sformatf("v%0d.count", i), 32'(count),     32'(vecs[i].e_cnt));
      check($sformatf("v%0d.full", i),  32'(full),      32'(vecs[i].e_full));
      check($sformatf("v%0d.empty", i), 32'(empty),     32'(vecs[i].e_empty));
      check($sformatf("v%0d.oerr", i),  32'(order_err), 32'(vecs[i].e_oerr));
    end

    // The sticky order error clears only on reset.
    @(negedge clk);
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    #1;
    check("oerr_sticky", 32'(order_err), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_oerr", 32'(order_err), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Duplicate rd: the younger copy keeps raw asserted while the head retires.
    drive(1, 5, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    drive(1, 5, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    drive(0, 0, 5, 0, 2'b01, 1, 5);
    #1;
    check("dup_raw", 32'(raw), 32'd1);
    check("dup_cnt", 32'(count), 32'd2);
    @(negedge clk);
    drive(0, 0, 5, 0, 2'b01, 0, 0);
    #1;
    check("dup_cnt_after", 32'(count), 32'd1);
    check("dup_raw_after", 32'(raw), 32'd1);
    check("dup_oerr", 32'(order_err), 32'd0);

    // A retire with the wrong rd still pops the entry and flags the error.
    drive(0, 0, 0, 0, 2'b00, 1, 4);
    @(negedge clk);
    drive(0, 0, 5, 0, 2'b01, 0, 0);
    #1;
    check("mis_oerr", 32'(order_err), 32'd1);
    check("mis_cnt", 32'(count), 32'd0);
    check("mis_raw", 32'(raw), 32'd0);

    // Asynchronous reset in mid-cycle discards live entries, and the next dispatch is accepted.
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    drive(1, 7, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    drive(1, 9, 7, 0, 2'b01, 0, 0);
    @(posedge clk);
    #2;
    drive(0, 0, 7, 0, 2'b01, 0, 0);
    rst = 1'b0;
    #1;
    check("arst_cnt", 32'(count), 32'd0);
    check("arst_raw", 32'(raw), 32'd0);
    check("arst_oerr", 32'(order_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 9, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    drive(0, 0, 9, 0, 2'b01, 0, 0);
    #1;
    check("post_rst_cnt", 32'(count), 32'd1);
    check("post_rst_raw", 32'(raw), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/witf_tracker.md
# witf_tracker

Parametrised write-in-flight tracker for the in-order decode/issue path: records the destination register of every dispatched register-writing instruction until its write-back retires. It flags read-after-write hazards for the instruction in decode and back-pressures dispatch when the tracker is full. It sits between the decode stage (dispatch/RAW query) and the write-back stage (retire), and replaces the fixed-size WITF with a configurable depth and source count.

## Interface
- DEPTH, 4: number of in-flight entries; power of two, 2..16.
- NSRC, 2: number of source-register operands checked per instruction.
- AW, 5: register address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- disp_en  in  1  dispatch request: push disp_rd this cycle.
- disp_rd  in  AW  destination register of dispatching instruction.
- rs  in  NSRC*AW  packed source addresses; source i at bits [i*AW +: AW].
- rs_valid  in  NSRC  per-source "operand is read" mask.
- wb_valid  in  1  write-back retire of oldest in-flight writer.
- wb_rd  in  AW  destination register being retired.
- raw  out  1  hazard: some valid, nonzero source matches a live entry.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  live entry count.
- order_err  out  1  sticky retire-ordering error.

## Operation
- Storage: circular buffer of DEPTH entries {valid, rd}; head (oldest) and tail pointers, $clog2(DEPTH) bits each, wrap modulo DEPTH.
- Push: accepted iff disp_en && !full && disp_rd != 0. Writes {1, disp_rd} at tail, tail+1. disp_rd == 0 is silently dropped (x0 is never tracked). disp_en while full is dropped; the caller must gate dispatch with full.
- Pop: on wb_valid && !empty, invalidate head, head+1. Retire is strictly in order.
- Ordering check: wb_valid && empty -> order_err set, no pop. wb_valid && wb_rd != head rd -> order_err set, pop still performed. order_err clears only on reset.
- Simultaneous push and pop: both take effect; count unchanged. When full, push is rejected even if a pop occurs in the same cycle.
- RAW: raw = OR over i of (rs_valid[i] && rs[i] != 0 && rs[i] matches rd of any valid entry). Duplicate rd entries are permitted; any match asserts raw.
- Flush is not handled here. Already-dispatched instructions always reach write-back, so entries are never cancelled. Flush only gates disp_en upstream.

## Timing
- Reset (rst low, asynchronous): all valid bits 0, head = tail = 0, count = 0, empty = 1, full = 0, raw = 0 (no live entries), order_err = 0.
- Reset released mid-operation: all prior entries are lost. Dispatch is legal in the first cycle after release.
- raw, full, empty, count: combinational from registered state (plus wb inputs when bypass is enabled). No input-to-state latency beyond one edge.
- A push at edge N is visible to raw, count and full from cycle N+1. A source matching a register being dispatched in the same cycle does not assert raw; the caller serialises.
- A pop at edge N removes the match from cycle N+1 (baseline).
- Pointer wrap: after DEPTH pushes, tail returns to 0. full is derived from count, never from pointer equality alone.

## Configuration
- WITF_WB_BYPASS_EN defined: the head entry being retired in the current cycle (wb_valid && !empty) is excluded from the RAW match. A dependant can issue in the same cycle its producer writes back, provided the regfile write-through forwards the value. If the same rd also exists in a younger live entry, raw still asserts.
- Undefined: raw considers all valid entries regardless of wb_valid. A dependant issues one cycle after retire.

## Test plan
- Reset, then push rd=5,6,7,8 (DEPTH=4) -> count=4, full=1. Further push rd=9 dropped; count stays 4.
- One live entry rd=5; rs={5,3}, rs_valid=2'b01 -> raw=1. rs_valid=2'b10 -> raw=0. rs={0,0} with rd=0 dispatch attempted -> no push, raw=0.
- Full tracker with simultaneous push rd=9 and wb_valid rd=5 -> count=3 next cycle, rd=9 absent (raw=0 for rs=9).
- Non-full: push rd=10 with wb_valid same cycle -> count unchanged. Wrap across 2*DEPTH operations keeps FIFO order with no order_err.
- wb_valid on empty -> order_err=1, count=0. wb_rd=4 while head rd=5 -> order_err=1 and entry popped. Reset clears order_err.
- Live rd=5 at head, wb_valid rd=5, rs=5 -> raw=0 with WITF_WB_BYPASS_EN, raw=1 without. A second live younger rd=5 -> raw=1 in both builds.
